// File: rtl/bootrom_port_ctrl_if.sv
// rtl/bootrom_port_ctrl_if.sv - CPU-side and ROM-side signal bundle for bootrom_port_ctrl
interface bootrom_port_ctrl_if #(
    parameter int AW = 9,
    parameter int DW = 32
);
    logic          i_req;
    logic [31:0]   i_addr;
    logic          i_ack;
    logic [DW-1:0] i_data;
    logic          d_req;
    logic          d_we;
    logic [31:0]   d_addr;
    logic          d_ack;
    logic [DW-1:0] d_data;
    logic          err;
    logic [1:0]    err_cause;
    logic          err_clr;
    logic          rom_ena;
    logic [AW-1:0] rom_addra;
    logic [DW-1:0] rom_doa;
    logic          rom_enb;
    logic [AW-1:0] rom_addrb;
    logic [DW-1:0] rom_dob;

    // Controller view.
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, err_clr, rom_doa, rom_dob,
        output i_ack, i_data, d_ack, d_data, err, err_cause,
        output rom_ena, rom_addra, rom_enb, rom_addrb
    );

    // Requester / ROM environment view.
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, err_clr, rom_doa, rom_dob,
        input  i_ack, i_data, d_ack, d_data, err, err_cause,
        input  rom_ena, rom_addra, rom_enb, rom_addrb
    );
endinterface

// File: rtl/bootrom_port_ctrl.sv
// rtl/bootrom_port_ctrl.sv - dual-port boot ROM front end with req/ack handshake (optional BOOTROM_FETCH_PREFETCH_EN)
module bootrom_port_ctrl #(
    parameter int AW = 9,
    parameter int DW = 32
) (
    input  logic                clk,
    input  logic                rst,
    bootrom_port_ctrl_if.slave  bus
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t        i_state_q, d_state_q;
    logic          i_ack_q, d_ack_q;
    logic [DW-1:0] i_data_q, d_data_q;
    logic          d_wr_q;
    logic          err_q;
    logic [1:0]    cause_q, cause_d;

    logic [AW-1:0] i_idx, d_idx;
    logic          i_accept, d_accept;
    logic          i_mis, d_mis;
    logic          unused_ok;

    assign i_idx    = bus.i_addr[AW+1:2];
    assign d_idx    = bus.d_addr[AW+1:2];
    assign i_mis    = |bus.i_addr[1:0];
    assign d_mis    = |bus.d_addr[1:0];
    assign i_accept = (i_state_q == IDLE) && bus.i_req;
    assign d_accept = (d_state_q == IDLE) && bus.d_req;

    // Upper address bits are decoded upstream.
    assign unused_ok = ^{bus.i_addr[31:AW+2], bus.d_addr[31:AW+2]};

    assign bus.rom_enb   = d_accept && !bus.d_we;
    assign bus.rom_addrb = d_idx;

`ifdef BOOTROM_FETCH_PREFETCH_EN
    logic [AW-1:0] i_idx_q, pf_issue_idx_q, pf_tag_q, pf_idx;
    logic [DW-1:0] pf_buf_q;
    logic          pf_pend_q, pf_valid_q, pf_issue, pf_hit;

    assign pf_idx        = i_idx_q + 1'b1;
    assign pf_issue      = (i_state_q == IDLE) && !bus.i_req;
    assign pf_hit        = pf_valid_q && (pf_tag_q == i_idx);
    assign bus.rom_ena   = (i_accept && !pf_hit) || pf_issue;
    assign bus.rom_addra = bus.i_req ? i_idx : pf_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            i_state_q      <= IDLE;
            i_ack_q        <= 1'b0;
            i_data_q       <= '0;
            i_idx_q        <= '0;
            pf_issue_idx_q <= '0;
            pf_tag_q       <= '0;
            pf_buf_q       <= '0;
            pf_pend_q      <= 1'b0;
            pf_valid_q     <= 1'b0;
        end else begin
            i_ack_q        <= 1'b0;
            pf_pend_q      <= pf_issue;
            pf_issue_idx_q <= pf_idx;
            // The ROM word for an issued prefetch appears one cycle later.
            if (pf_pend_q) begin
                pf_valid_q <= 1'b1;
                pf_tag_q   <= pf_issue_idx_q;
                pf_buf_q   <= bus.rom_doa;
            end
            case (i_state_q)
                IDLE: if (bus.i_req) begin
                    i_idx_q <= i_idx;
                    if (pf_hit) begin
                        i_ack_q  <= 1'b1;
                        i_data_q <= pf_buf_q;
                    end else begin
                        i_state_q <= WAIT;
                    end
                end
                WAIT: begin
                    i_data_q  <= bus.rom_doa;
                    i_ack_q   <= 1'b1;
                    i_state_q <= IDLE;
                end
                default: i_state_q <= IDLE;
            endcase
        end
    end
`else
    assign bus.rom_ena   = i_accept;
    assign bus.rom_addra = i_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            i_state_q <= IDLE;
            i_ack_q   <= 1'b0;
            i_data_q  <= '0;
        end else begin
            i_ack_q <= 1'b0;
            case (i_state_q)
                IDLE: if (bus.i_req) i_state_q <= WAIT;
                WAIT: begin
                    i_data_q  <= bus.rom_doa;
                    i_ack_q   <= 1'b1;
                    i_state_q <= IDLE;
                end
                default: i_state_q <= IDLE;
            endcase
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            d_state_q <= IDLE;
            d_ack_q   <= 1'b0;
            d_data_q  <= '0;
            d_wr_q    <= 1'b0;
        end else begin
            d_ack_q <= 1'b0;
            case (d_state_q)
                IDLE: if (bus.d_req) begin
                    d_wr_q    <= bus.d_we;
                    d_state_q <= WAIT;
                end
                WAIT: begin
                    // A write completes the handshake but never touches the read data.
                    if (!d_wr_q) d_data_q <= bus.rom_dob;
                    d_ack_q   <= 1'b1;
                    d_state_q <= IDLE;
                end
                default: d_state_q <= IDLE;
            endcase
        end
    end

    // A clear coinciding with a new error still records the new error.
    always_comb begin
        cause_d = (bus.err_clr ? 2'b00 : cause_q)
                | {(i_accept && i_mis) || (d_accept && d_mis), d_accept && bus.d_we};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cause_q <= 2'b00;
            err_q   <= 1'b0;
        end else begin
            cause_q <= cause_d;
            err_q   <= |cause_d;
        end
    end

    assign bus.i_ack     = i_ack_q;
    assign bus.i_data    = i_data_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.d_data    = d_data_q;
    assign bus.err       = err_q;
    assign bus.err_cause = cause_q;

endmodule
